// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions for the round core and the message-schedule
// stages: round-constant table K[0..63], initial hash value, the round-core
// FSM state type, the packed working-variable struct {a..h} and the
// Sigma0/Sigma1/Ch/Maj round functions.
// ---------------------------------------------------------------------------
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Working variables; field a occupies [255:224], so a 256-bit chaining
    // value {A,B,C,D,E,F,G,H} casts directly onto this struct.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Ascending packed range so that K_TABLE[0] is the first listed word.
    localparam logic [0:63][31:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e,
                                       input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word-wise modulo-2^32 sum of two working-variable sets.
    function automatic work_t add_words(input work_t x, input work_t y);
        work_t s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// ---------------------------------------------------------------------------
// sha256_round_comb
// One SHA-256 compression round, purely combinational.
//   cur : working variables A..H entering the round
//   k   : round constant K[t]
//   w   : schedule word W[t]
//   nxt : working variables A..H after the round
// ---------------------------------------------------------------------------
module sha256_round_comb
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    // NOTE: every variable written here is assigned on every pass through the
    // block, so no latch is inferred.
    always_comb begin
        t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end

endmodule

// File: rtl/sha256_round_core.sv
// ---------------------------------------------------------------------------
// sha256_round_core
// Iterative SHA-256 compression: one round per clock, 64 rounds per block.
// The message schedule lives upstream; this core consumes W[t] from the head
// of that window and requests the next word with w_adv.
//   CLK    : clock, rising edge
//   RST    : asynchronous active-high reset
//   start  : begin a compression (accepted only when idle)
//   h_in   : chaining value {A..H}, A in [255:224], sampled on accepted start
//   w_in   : current schedule word W[t]
//   w_adv  : advance request to the schedule window (high in every round)
//   busy   : compression in progress (RUN or FIN)
//   done   : one-cycle pulse, digest valid
//   digest : h_in + final working variables, same word order as h_in
// Timing: start edge E0, rounds 0..63 at E1..E64, digest/done at E65.
// ---------------------------------------------------------------------------
module sha256_round_core
    import sha256_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic [31:0]  w_in,
    output logic         w_adv,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    state_t      state;
    logic [5:0]  t;
    work_t       work;
    work_t       saved;
    work_t       nxt_work;

    sha256_round_comb u_round (
        .cur (work),
        .k   (K_TABLE[t]),
        .w   (w_in),
        .nxt (nxt_work)
    );

    // Decoded straight from the state register, so both are glitch-free and
    // drop to zero together with the state on reset.
    assign busy  = (state != ST_IDLE);
    assign w_adv = (state == ST_RUN);

    // NOTE: all state here is sequential and updated with non-blocking
    // assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            t      <= '0;
            work   <= '0;
            saved  <= '0;
            digest <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work  <= work_t'(h_in);
                        saved <= work_t'(h_in);
                        t     <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work <= nxt_work;
                    // 6-bit counter wraps 63->0 on the same edge that leaves RUN.
                    t    <= t + 6'd1;
                    if (t == 6'd63) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    digest <= add_words(saved, work);
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_core.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_core
// Self-checking bench for sha256_round_core. Acts as the upstream schedule
// window (expands 16 message words to 64 and advances on w_adv) and compares
// digests against known SHA-256 vectors and a plain-arithmetic reference
// compression whose round constants are derived from cube roots of primes.
// ---------------------------------------------------------------------------
module tb_sha256_round_core;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic [255:0] h_in;
    logic [31:0]  w_in;
    logic         w_adv;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    sha256_round_core dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .h_in   (h_in),
        .w_in   (w_in),
        .w_adv  (w_adv),
        .busy   (busy),
        .done   (done),
        .digest (digest)
    );

    always #5 CLK = ~CLK;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          idx        = 0;
    int          adv_count  = 0;
    int          done_count = 0;
    int          start_cyc  = 0;
    logic [31:0] kref  [64];
    logic [31:0] msg   [16];
    logic [31:0] sched [64];

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic bit is_prime(input int n);
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // K[i] = first 32 bits of the fractional part of cbrt(i-th prime).
    task automatic build_k();
        int  n = 2;
        int  cnt = 0;
        real c;
        real frac_bits;
        while (cnt < 64) begin
            if (is_prime(n)) begin
                c = real'(n) ** (1.0 / 3.0);
                frac_bits = $floor((c - $floor(c)) * 4294967296.0);
                kref[cnt] = 32'(longint'(frac_bits));
                cnt++;
            end
            n++;
        end
    endtask

    // Expand msg[] into the 64-word window and rewind it to W0.
    task automatic load_sched();
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                sched[i] = msg[i];
            end else begin
                s0 = rotr(sched[i-15], 7) ^ rotr(sched[i-15], 18) ^ (sched[i-15] >> 3);
                s1 = rotr(sched[i-2], 17) ^ rotr(sched[i-2], 19) ^ (sched[i-2] >> 10);
                sched[i] = s1 + sched[i-7] + s0 + sched[i-16];
            end
        end
        idx  = 0;
        w_in = sched[0];
    endtask

    // Reference compression of the currently loaded schedule.
    function automatic logic [255:0] model_compress(input logic [255:0] h);
        logic [31:0]  v [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kref[t] + sched[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    // One clock: inputs change and outputs are sampled 1 time unit after the
    // rising edge. The window pops when w_adv was high across that edge.
    task automatic tick();
        logic adv;
        adv = w_adv;
        @(posedge CLK);
        #1;
        cyc++;
        if (adv) begin
            idx++;
            adv_count++;
        end
        w_in = (idx < 64) ? sched[idx] : 32'h0;
        if (done) done_count++;
    endtask

    task automatic set_msg_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_msg_empty();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0] = 32'h80000000;
    endtask

    // Load the window, pulse start for one edge, then scramble h_in.
    task automatic start_block(input logic [255:0] h);
        load_sched();
        h_in  = h;
        start = 1'b1;
        tick();
        start_cyc = cyc;
        start = 1'b0;
        h_in  = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        bit seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check(tag, 256'(seen), 256'(1));
    endtask

    initial begin
        int          d1;
        int          d2;
        int          n0;
        int          a0;
        logic [255:0] h_r;
        logic [255:0] exp_d;

        build_k();
        RST   = 1'b1;
        start = 1'b0;
        h_in  = '0;
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        load_sched();
        repeat (3) tick();
        check("reset_digest", digest, 256'h0);
        check("reset_flags", {done, busy, w_adv}, 256'h0);
        RST = 1'b0;

        // "abc" block, then the empty message started in the done cycle.
        set_msg_abc();
        start_block(IV);
        check("abc_busy", 256'(busy), 256'(1));
        wait_done("abc_done_seen", d1);
        check("abc_digest", digest, ABC_DIGEST);
        check("abc_latency", 256'(d1 - start_cyc), 256'(65));

        set_msg_empty();
        start_block(IV);
        check("b2b_done_width", 256'(done), 256'(0));
        check("b2b_accepted", 256'(busy), 256'(1));
        check("digest_hold", digest, ABC_DIGEST);
        wait_done("empty_done_seen", d2);
        check("empty_digest", digest, EMPTY_DIGEST);
        check("b2b_spacing", 256'(d2 - d1), 256'(66));
        tick();
        check("idle_after_done", 256'({busy, done}), 256'(0));

        // Starts at cycles 10 and 30 of a run must be ignored.
        set_msg_abc();
        n0 = done_count;
        a0 = adv_count;
        start_block(IV);
        repeat (9) tick();
        start = 1'b1;
        h_in  = {8{$urandom}};
        tick();
        start = 1'b0;
        repeat (19) tick();
        start = 1'b1;
        h_in  = {8{$urandom}};
        tick();
        start = 1'b0;
        wait_done("rep_done_seen", d1);
        check("rep_digest", digest, ABC_DIGEST);
        check("rep_latency", 256'(d1 - start_cyc), 256'(65));
        repeat (5) tick();
        check("rep_done_count", 256'(done_count - n0), 256'(1));
        check("rep_adv_count", 256'(adv_count - a0), 256'(64));

        // Modulo-2^32 wrap: every word all ones.
        for (int i = 0; i < 16; i++) msg[i] = 32'hffffffff;
        start_block({256{1'b1}});
        exp_d = model_compress({256{1'b1}});
        wait_done("wrap_done_seen", d1);
        check("wrap_digest", digest, exp_d);

        // Random chaining values and messages.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) msg[i] = $urandom;
            h_r = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            start_block(h_r);
            exp_d = model_compress(h_r);
            wait_done($sformatf("rand%0d_done_seen", r), d1);
            check($sformatf("rand%0d_digest", r), digest, exp_d);
        end

        // Reset around round 20: outputs clear without a clock edge, the
        // aborted block never reports, and the next start goes straight in.
        set_msg_abc();
        start_block(IV);
        repeat (20) tick();
        n0 = done_count;
        #2 RST = 1'b1;
        #1;
        check("midrst_digest", digest, 256'h0);
        check("midrst_flags", {done, busy, w_adv}, 256'h0);
        repeat (3) tick();
        RST = 1'b0;
        start_block(IV);
        wait_done("post_rst_done_seen", d1);
        check("post_rst_digest", digest, ABC_DIGEST);
        check("post_rst_latency", 256'(d1 - start_cyc), 256'(65));
        check("post_rst_done_count", 256'(done_count - n0), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
